// File: rtl/oai222_group_pipe.sv
// oai222_group_pipe: two-stage valid/ready pipeline computing the INV/OAI222
// group function over NUM_GROUPS 4-bit groups, with activity counting.
// Ports:
//   clk, rst (sync, active-high)
//   in_valid/in_ready, a, b, a_mask, b_mask, out_en : input word side
//   out_valid/out_ready, c                           : result side
//   clr_cnt, act_cnt                                 : activity counter
module oai222_group_pipe #(
  parameter int NUM_GROUPS = 10,
  parameter int CNT_W      = 16,
  localparam int W         = 4 * NUM_GROUPS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          a,
  input  logic [W-1:0]          b,
  input  logic [W-1:0]          a_mask,
  input  logic [W-1:0]          b_mask,
  input  logic [NUM_GROUPS-1:0] out_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [W-1:0]          c,
  input  logic                  clr_cnt,
  output logic [CNT_W-1:0]      act_cnt
);

  logic                  s1_valid;
  logic [W-1:0]          s1_a;
  logic [W-1:0]          s1_b;
  logic [NUM_GROUPS-1:0] s1_en;

  logic                  s2_valid;
  logic [W-1:0]          s2_c;

  logic [W-1:0]          last_c;
  logic [W-1:0]          f;

  logic                  in_fire;
  logic                  out_fire;
  logic                  s2_load;
  logic                  cnt_sat;

  // S1 may accept whenever something downstream will make room this edge.
  assign in_ready  = ~s1_valid | ~s2_valid | out_ready;
  assign in_fire   = in_valid & in_ready;
  assign s2_load   = s1_valid & (~s2_valid | out_ready);
  assign out_fire  = s2_valid & out_ready;
  assign out_valid = s2_valid;
  assign c         = s2_c;
  assign cnt_sat   = (act_cnt == {CNT_W{1'b1}});

  always_comb begin
    f = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      if (s1_en[g]) begin
        f[4*g]   = ~s1_a[4*g];
        f[4*g+1] = ~s1_b[4*g];
        f[4*g+2] = ~s1_b[4*g+1];
        f[4*g+3] = ~((s1_a[4*g+1] | s1_a[4*g+2]) &
                     (s1_b[4*g+1] | s1_b[4*g+2]) &
                     (s1_a[4*g+3] | s1_b[4*g+3]));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_en    <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_a     <= a & a_mask;
      s1_b     <= b & b_mask;
      s1_en    <= out_en;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_c     <= '0;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      s2_c     <= f;
    end else if (out_fire) begin
      s2_valid <= 1'b0;
    end
  end

  // Clear beats increment, but the reference result still advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_c  <= '0;
      act_cnt <= '0;
    end else begin
      if (out_fire) begin
        last_c <= s2_c;
      end
      if (clr_cnt) begin
        act_cnt <= '0;
      end else if (out_fire && (s2_c != last_c) && !cnt_sat) begin
        act_cnt <= act_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_oai222_group_pipe.sv
// tb_oai222_group_pipe: directed checks of oai222_group_pipe
// (function, masks, enables, stall/flow, counter, reset).
module tb_oai222_group_pipe;

  localparam int NG = 10;
  localparam int W  = 4 * NG;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [W-1:0]  a_mask;
  logic [W-1:0]  b_mask;
  logic [NG-1:0] out_en;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  c;
  logic          clr_cnt;
  logic [15:0]   act_cnt;

  logic          in_ready2;
  logic          out_valid2;
  logic [W-1:0]  c2;
  logic [1:0]    act_cnt2;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [W-1:0] ONES = {W{1'b1}};

  always #5 clk = ~clk;

  oai222_group_pipe #(.NUM_GROUPS(NG), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .a_mask(a_mask), .b_mask(b_mask),
    .out_en(out_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .clr_cnt(clr_cnt), .act_cnt(act_cnt)
  );

  oai222_group_pipe #(.NUM_GROUPS(NG), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .a_mask(a_mask), .b_mask(b_mask),
    .out_en(out_en),
    .out_valid(out_valid2), .out_ready(out_ready),
    .c(c2), .clr_cnt(clr_cnt), .act_cnt(act_cnt2)
  );

  function automatic logic [W-1:0] expand(input logic [NG-1:0] en);
    logic [W-1:0] r;
    r = '0;
    for (int g = 0; g < NG; g++) r[4*g +: 4] = en[g] ? 4'hF : 4'h0;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send1(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic [W-1:0] tam, input logic [W-1:0] tbm,
                       input logic [NG-1:0] ten);
    a = ta; b = tb; a_mask = tam; b_mask = tbm; out_en = ten;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    int sent;
    int rd;
    int gaps;
    logic saw_stall;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
    a = '0; b = '0; a_mask = ONES; b_mask = ONES; out_en = '1;
    step(); step();
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_c", c, 0);
    chk("rst_act_cnt", act_cnt, 0);
    chk("rst_in_ready", in_ready, 1);

    // all-zero operands -> every group 4'hF, 2-edge latency
    send1('0, '0, ONES, ONES, '1);
    chk("lat_not_yet", out_valid, 0);
    step();
    chk("lat_valid", out_valid, 1);
    chk("zero_ops_c", c, ONES);
    step();
    chk("act_after_1", act_cnt, 1);
    chk("drained", out_valid, 0);

    // all-ones operands -> 0
    send1(ONES, ONES, ONES, ONES, '1);
    step();
    chk("ones_ops_c", c, 0);
    step();

    // group 0 masked pins: c0=0 c1=0 c2=1 c3=1
    send1(ONES, ONES, ~W'(40'hE), ~W'(40'h6), '1);
    step();
    chk("mask_g0_c", c, 40'hC);
    step();
    chk("act_after_3", act_cnt, 3);

    // alternating enables, out_en changed while in flight
    send1('0, '0, ONES, ONES, 10'h2AA);
    out_en = '1;
    step();
    chk("out_en_alt_c", c, 40'hF0F0F0F0F0);
    step();
    chk("act_after_4", act_cnt, 4);

    // 8-word stream with out_ready low for cycles 3..6
    sent = 0; rd = 0; gaps = 0; saw_stall = 1'b0;
    a = '0; b = '0; a_mask = ONES; b_mask = ONES;
    for (int cyc = 0; cyc < 40 && rd < 8; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 6);
      in_valid  = (sent < 8);
      out_en    = NG'(sent + 1);
      #1;
      if (!in_ready) saw_stall = 1'b1;
      if (rd > 0 && !out_valid) gaps++;
      if (out_valid && out_ready) begin
        chk("stream_c", c, expand(NG'(rd + 1)));
        rd++;
      end
      if (in_valid && in_ready) sent++;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream_count", rd, 8);
    chk("stream_stall_seen", saw_stall, 1);
    chk("stream_no_bubble", gaps, 0);
    chk("act_after_stream", act_cnt, 12);

    // identical word three times: one increment
    for (int i = 0; i < 3; i++) begin
      send1('0, '0, ONES, ONES, '1);
      step(); step();
    end
    chk("act_identical", act_cnt, 13);

    // clear during a differing handshake
    send1(ONES, ONES, ONES, ONES, '1);
    step();
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    chk("act_cleared", act_cnt, 0);
    send1(ONES, ONES, ONES, ONES, '1);
    step(); step();
    chk("act_after_clr_same", act_cnt, 0);

    // fill both stages, then reset
    out_ready = 1'b0;
    a = '0; b = '0; out_en = '1;
    in_valid = 1'b1;
    step(); step();
    in_valid = 1'b0;
    chk("full_out_valid", out_valid, 1);
    chk("full_in_ready", in_ready, 0);
    rst = 1'b1;
    step();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_c", c, 0);
    chk("midrst_act_cnt", act_cnt, 0);
    chk("midrst_in_ready", in_ready, 1);
    rst = 1'b0; out_ready = 1'b1;
    step(); step();
    chk("midrst_no_leftover", out_valid, 0);

    // 5 alternating words: 16-bit counter 5, 2-bit counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      a = (i % 2 == 0) ? '0 : ONES;
      b = a;
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step(); step(); step();
    chk("sat_wide", act_cnt, 5);
    chk("sat_narrow", act_cnt2, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
